// File: rtl/uart_alu_interface.sv
// Sequences UART bytes into ALU operands/operator, captures the ALU result and
// requests its transmission; partial frames are dropped after an idle timeout.
module uart_alu_interface #(
  parameter int NB_DATA     = 8,
  parameter int NB_OPERADOR = 6,
  parameter int TIMEOUT     = 50000
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [NB_DATA-1:0]     i_rx_data,
  input  logic                   i_rx_done,
  input  logic [NB_DATA-1:0]     i_alu_result,
  input  logic                   i_tx_done,
  output logic [NB_DATA-1:0]     o_dato_a,
  output logic [NB_DATA-1:0]     o_dato_b,
  output logic [NB_OPERADOR-1:0] o_operador,
  output logic                   o_alu_valid,
  output logic [NB_DATA-1:0]     o_tx_data,
  output logic                   o_tx_start,
  output logic                   o_busy,
  output logic                   o_timeout
);

  localparam int NB_CNT = $clog2(TIMEOUT + 1);
  localparam logic [NB_CNT-1:0] TIMEOUT_VAL = NB_CNT'(TIMEOUT);
  localparam logic [NB_CNT-1:0] CNT_ONE     = NB_CNT'(1);

  typedef enum logic [2:0] {
    RX_A    = 3'd0,
    RX_B    = 3'd1,
    RX_OP   = 3'd2,
    EXEC    = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_t;

  state_t                 state_r;
  state_t                 state_next_s;
  logic                   accept_s;
  logic                   timeout_s;
  logic [NB_CNT-1:0]      idle_cnt_r;
  logic [NB_DATA-1:0]     dato_a_r;
  logic [NB_DATA-1:0]     dato_b_r;
  logic [NB_OPERADOR-1:0] operador_r;
  logic [NB_DATA-1:0]     tx_data_r;
  logic                   alu_valid_r;
  logic                   tx_start_r;
  logic                   busy_r;
  logic                   timeout_r;

  function automatic logic is_busy(input state_t s);
    return (s == EXEC) || (s == SEND) || (s == WAIT_TX);
  endfunction

  function automatic logic is_collecting(input state_t s);
    return (s == RX_B) || (s == RX_OP);
  endfunction

  // Next-state decode; a byte arriving on the timeout cycle wins over the timeout.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    timeout_s    = 1'b0;
    case (state_r)
      RX_A: begin
        if (i_rx_done) begin
          accept_s     = 1'b1;
          state_next_s = RX_B;
        end else begin
          state_next_s = RX_A;
        end
      end
      RX_B: begin
        if (i_rx_done) begin
          accept_s     = 1'b1;
          state_next_s = RX_OP;
        end else if (idle_cnt_r == TIMEOUT_VAL) begin
          timeout_s    = 1'b1;
          state_next_s = RX_A;
        end else begin
          state_next_s = RX_B;
        end
      end
      RX_OP: begin
        if (i_rx_done) begin
          accept_s     = 1'b1;
          state_next_s = EXEC;
        end else if (idle_cnt_r == TIMEOUT_VAL) begin
          timeout_s    = 1'b1;
          state_next_s = RX_A;
        end else begin
          state_next_s = RX_OP;
        end
      end
      EXEC:    state_next_s = SEND;
      SEND:    state_next_s = WAIT_TX;
      WAIT_TX: begin
        if (i_tx_done) begin
          state_next_s = RX_A;
        end else begin
          state_next_s = WAIT_TX;
        end
      end
      default: state_next_s = RX_A;
    endcase
  end

  // State, datapath registers and strobes registered from the next state.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r     <= RX_A;
      idle_cnt_r  <= '0;
      dato_a_r    <= '0;
      dato_b_r    <= '0;
      operador_r  <= '0;
      tx_data_r   <= '0;
      alu_valid_r <= 1'b0;
      tx_start_r  <= 1'b0;
      busy_r      <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      alu_valid_r <= (state_next_s == EXEC);
      tx_start_r  <= (state_next_s == SEND);
      busy_r      <= is_busy(state_next_s);
      timeout_r   <= timeout_s;

      if (accept_s || !is_collecting(state_r)) begin
        idle_cnt_r <= '0;
      end else if (idle_cnt_r != TIMEOUT_VAL) begin
        idle_cnt_r <= idle_cnt_r + CNT_ONE;
      end

      if (accept_s && (state_r == RX_A)) begin
        dato_a_r <= i_rx_data;
      end
      if (accept_s && (state_r == RX_B)) begin
        dato_b_r <= i_rx_data;
      end
      if (accept_s && (state_r == RX_OP)) begin
        operador_r <= i_rx_data[NB_OPERADOR-1:0];
      end
      if (state_r == EXEC) begin
        tx_data_r <= i_alu_result;
      end
    end
  end

  assign o_dato_a    = dato_a_r;
  assign o_dato_b    = dato_b_r;
  assign o_operador  = operador_r;
  assign o_alu_valid = alu_valid_r;
  assign o_tx_data   = tx_data_r;
  assign o_tx_start  = tx_start_r;
  assign o_busy      = busy_r;
  assign o_timeout   = timeout_r;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Directed bench for uart_alu_interface with a behavioural ALU and TIMEOUT=16.
module tb_uart_alu_interface;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_done;
  logic [7:0] alu_result;
  logic       tx_done;
  logic [7:0] dato_a;
  logic [7:0] dato_b;
  logic [5:0] operador;
  logic       alu_valid;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       timeout;

  int passed = 0;
  int total  = 0;

  uart_alu_interface #(.NB_DATA(8), .NB_OPERADOR(6), .TIMEOUT(16)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_rx_data    (rx_data),
    .i_rx_done    (rx_done),
    .i_alu_result (alu_result),
    .i_tx_done    (tx_done),
    .o_dato_a     (dato_a),
    .o_dato_b     (dato_b),
    .o_operador   (operador),
    .o_alu_valid  (alu_valid),
    .o_tx_data    (tx_data),
    .o_tx_start   (tx_start),
    .o_busy       (busy),
    .o_timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: ADD, SUB, AND, otherwise OR.
  always_comb begin
    case (operador)
      6'b100000: alu_result = dato_a + dato_b;
      6'b100010: alu_result = dato_a - dato_b;
      6'b100100: alu_result = dato_a & dato_b;
      default:   alu_result = dato_a | dato_b;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Called at a negedge; the byte is sampled on the following posedge.
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic exec_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                            input logic [5:0] exp_op, input logic [7:0] exp_res);
    send_byte(a);
    check("busy_after_a", 32'(busy), 32'd0);
    send_byte(b);
    send_byte(opb);
    check("alu_valid_hi", 32'(alu_valid), 32'd1);
    check("dato_a", 32'(dato_a), 32'(a));
    check("dato_b", 32'(dato_b), 32'(b));
    check("operador", 32'(operador), 32'(exp_op));
    check("busy_exec", 32'(busy), 32'd1);
    check("tx_start_lo_exec", 32'(tx_start), 32'd0);
    @(negedge clk);
    check("alu_valid_lo", 32'(alu_valid), 32'd0);
    check("tx_start_hi", 32'(tx_start), 32'd1);
    check("tx_data", 32'(tx_data), 32'(exp_res));
    @(negedge clk);
    check("tx_start_lo", 32'(tx_start), 32'd0);
    check("busy_wait_tx", 32'(busy), 32'd1);
  endtask

  task automatic finish_tx();
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    check("busy_fall", 32'(busy), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_a"}, 32'(dato_a), 32'd0);
    check({tag, "_b"}, 32'(dato_b), 32'd0);
    check({tag, "_op"}, 32'(operador), 32'd0);
    check({tag, "_txd"}, 32'(tx_data), 32'd0);
    check({tag, "_flags"}, {28'd0, alu_valid, tx_start, busy, timeout}, 32'd0);
  endtask

  initial begin
    int to_cnt;
    int av_cnt;
    rst = 1'b1; rx_data = 8'h00; rx_done = 1'b0; tx_done = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Stray tx_done while idle has no effect
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    check("txdone_idle_busy", 32'(busy), 32'd0);

    exec_frame(8'h05, 8'h03, 8'h20, 6'b100000, 8'h08);
    finish_tx();
    exec_frame(8'hFA, 8'h02, 8'hE2, 6'b100010, 8'hF8);

    // Byte during WAIT_TX is ignored
    send_byte(8'h11);
    check("wait_rx_dato_a", 32'(dato_a), 32'hFA);
    check("wait_rx_busy", 32'(busy), 32'd1);
    check("wait_rx_start", 32'(tx_start), 32'd0);
    finish_tx();
    exec_frame(8'h0C, 8'h0A, 8'h24, 6'b100100, 8'h08);
    finish_tx();

    // Partial frame times out once
    send_byte(8'h33);
    to_cnt = 0;
    av_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      to_cnt += int'(timeout);
      av_cnt += int'(alu_valid);
    end
    check("timeout_pulses", 32'(to_cnt), 32'd1);
    check("timeout_no_valid", 32'(av_cnt), 32'd0);
    check("timeout_keep_a", 32'(dato_a), 32'h33);
    exec_frame(8'h07, 8'h02, 8'h22, 6'b100010, 8'h05);
    finish_tx();

    // Second byte on the exact timeout cycle is accepted
    send_byte(8'h40);
    to_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      to_cnt += int'(timeout);
    end
    send_byte(8'h01);
    to_cnt += int'(timeout);
    check("edge_no_timeout", 32'(to_cnt), 32'd0);
    check("edge_dato_b", 32'(dato_b), 32'h01);
    send_byte(8'h20);
    check("edge_alu_valid", 32'(alu_valid), 32'd1);
    @(negedge clk);
    check("edge_tx_data", 32'(tx_data), 32'h41);
    @(negedge clk);
    finish_tx();

    // Reset in RX_OP
    send_byte(8'h09);
    send_byte(8'h04);
    #2 rst = 1'b1;
    #1 check_zero("rst_rxop");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exec_frame(8'h06, 8'h01, 8'h20, 6'b100000, 8'h07);

    // Reset in WAIT_TX
    #2 rst = 1'b1;
    #1 check_zero("rst_waittx");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exec_frame(8'h02, 8'h02, 8'h20, 6'b100000, 8'h04);
    finish_tx();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
